// File: rtl/tinker_mem_pkg.sv
// Shared types and widths for the CPU memory-port arbiter.
package tinker_mem_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_L, RESP} arb_state_t;
   typedef enum logic {OWN_F, OWN_L} owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of cycles the fetch side waits; sat forces a fetch win.
module arb_starve_counter #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CW = $clog2(MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign sat = (cnt_q == CW'(MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && !sat)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (F) and LSU (L): L priority with a starvation guard for F.
// Optional MEM_ARB_PERF_EN adds grant and fetch-stall performance counters.
module mem_port_arbiter
   import tinker_mem_pkg::*;
#(
   parameter int ADDR_W     = tinker_mem_pkg::ADDR_W,
   parameter int DATA_W     = tinker_mem_pkg::DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic              f_flush,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_f_grants,
   output logic [31:0]       perf_l_grants,
   output logic [31:0]       perf_f_stall
`endif
);

   arb_state_t        state_q, state_d;
   logic              f_gnt_q, f_gnt_d, l_gnt_q, l_gnt_d;
   logic              f_rvalid_q, f_rvalid_d, l_rvalid_q, l_rvalid_d;
   logic [DATA_W-1:0] f_rdata_q, f_rdata_d, l_rdata_q, l_rdata_d;
   logic              m_req_q, m_req_d, m_we_q, m_we_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic              flush_q, flush_d;

   owner_t winner;
   logic   arb_go;
   logic   f_win;
   logic   starve_sat;
   logic   starve_inc;
   logic   starve_clr;

   // L wins unless F is saturated and actually waiting.
   assign winner     = (l_req && (!starve_sat || !f_req)) ? OWN_L : OWN_F;
   assign arb_go     = (state_q == IDLE) && (f_req || l_req);
   assign f_win      = arb_go && (winner == OWN_F);
   assign starve_inc = f_req && !f_win;
   assign starve_clr = !f_req || f_win;

   arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .sat   (starve_sat)
   );

   always_comb begin
      state_d    = state_q;
      f_gnt_d    = 1'b0;
      l_gnt_d    = 1'b0;
      f_rvalid_d = 1'b0;
      l_rvalid_d = 1'b0;
      f_rdata_d  = f_rdata_q;
      l_rdata_d  = l_rdata_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      flush_d    = flush_q;
      case (state_q)
         IDLE: begin
            if (arb_go) begin
               m_req_d = 1'b1;
               if (winner == OWN_L) begin
                  state_d   = BUSY_L;
                  l_gnt_d   = 1'b1;
                  m_we_d    = l_we;
                  m_addr_d  = l_addr;
                  m_wdata_d = l_wdata;
               end else begin
                  state_d   = BUSY_F;
                  f_gnt_d   = 1'b1;
                  m_we_d    = 1'b0;
                  m_addr_d  = f_addr;
                  m_wdata_d = '0;
               end
            end
         end
         BUSY_F: begin
            if (f_flush)
               flush_d = 1'b1;
            if (m_ack) begin
               m_req_d = 1'b0;
               state_d = RESP;
               // A flush in the ack cycle itself must also kill this response.
               if (!(flush_q || f_flush)) begin
                  f_rvalid_d = 1'b1;
                  f_rdata_d  = m_rdata;
               end
            end
         end
         BUSY_L: begin
            if (m_ack) begin
               m_req_d    = 1'b0;
               state_d    = RESP;
               l_rvalid_d = 1'b1;
               l_rdata_d  = m_we_q ? '0 : m_rdata;
            end
         end
         RESP: begin
            state_d = IDLE;
            flush_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         f_gnt_q    <= 1'b0;
         l_gnt_q    <= 1'b0;
         f_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
         f_rdata_q  <= '0;
         l_rdata_q  <= '0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         f_gnt_q    <= f_gnt_d;
         l_gnt_q    <= l_gnt_d;
         f_rvalid_q <= f_rvalid_d;
         l_rvalid_q <= l_rvalid_d;
         f_rdata_q  <= f_rdata_d;
         l_rdata_q  <= l_rdata_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         flush_q    <= flush_d;
      end
   end

   assign f_gnt    = f_gnt_q;
   assign l_gnt    = l_gnt_q;
   assign f_rvalid = f_rvalid_q;
   assign l_rvalid = l_rvalid_q;
   assign f_rdata  = f_rdata_q;
   assign l_rdata  = l_rdata_q;
   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_f_grants_q, perf_f_grants_d;
   logic [31:0] perf_l_grants_q, perf_l_grants_d;
   logic [31:0] perf_f_stall_q, perf_f_stall_d;

   always_comb begin
      perf_f_grants_d = perf_f_grants_q + 32'(f_gnt_d);
      perf_l_grants_d = perf_l_grants_q + 32'(l_gnt_d);
      perf_f_stall_d  = perf_f_stall_q + 32'(starve_inc);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_f_grants_q <= '0;
         perf_l_grants_q <= '0;
         perf_f_stall_q  <= '0;
      end else begin
         perf_f_grants_q <= perf_f_grants_d;
         perf_l_grants_q <= perf_l_grants_d;
         perf_f_stall_q  <= perf_f_stall_d;
      end
   end

   assign perf_f_grants = perf_f_grants_q;
   assign perf_l_grants = perf_l_grants_q;
   assign perf_f_stall  = perf_f_stall_q;
`endif

endmodule
